niosii_system_pio_in_edge: RTL and testbench
============================================

// Module: niosII_system_pio_in_edge
// PURPOSE
//  Parametrised Avalon-MM input PIO for board switches/keys: multi-bit, configurable synchroniser depth.
//  Per-bit edge capture with selectable edge type, write-1-to-clear capture, maskable level IRQ to Nios II.
//  Sits on the system interconnect as slave s1; in_port driven by DE2 switches/keys.
// PARAMETERS
//  WIDTH        8   number of input bits (1..32)
//  SYNC_STAGES  2   synchroniser flops per bit (2..4)
//  EDGE_TYPE    0   0=any edge, 1=rising, 2=falling (applies to all bits)
//  DB_CYCLES    16  debounce stability window in clk cycles (2..65535); used only with PIO_IN_DEBOUNCE_EN
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   2      word address: 0=data, 1=reserved, 2=irq_mask, 3=edge_capture
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe (valid with chipselect)
//  writedata   in   32     write data; bits [WIDTH-1:0] used
//  in_port     in   WIDTH  asynchronous external inputs
//  readdata    out  32     registered read data; bits [31:WIDTH] always 0
//  irq         out  1      level interrupt = |(edge_capture & irq_mask)
// BEHAVIOUR
//  Reset (async assert, sync release): readdata=0, irq_mask=0, edge_capture=0, all sync/debounce flops=0; irq=0.
//  Sync: in_port -> SYNC_STAGES flop chain per bit; sync_q = last stage. No reset-time edge: flops reset to 0,
//   so an input held high at release produces a rising edge SYNC_STAGES+1 cycles later (intended, documented).
//  Filtered value f = sync_q (or debounced value, see CONFIGURATION); f_d = f delayed 1 clk.
//  Edge detect per bit i: any: f[i]^f_d[i]; rising: f[i]&~f_d[i]; falling: ~f[i]&f_d[i].
//  Input-to-capture latency (no debounce): SYNC_STAGES+1 clks from in_port change to edge_capture bit set.
//  Read: readdata updates every clk with mux(address) regardless of chipselect; 1-cycle read latency.
//   addr0 -> f; addr1 -> 0; addr2 -> irq_mask; addr3 -> edge_capture.
//  Write addr2 (chipselect & ~write_n): irq_mask <= writedata[WIDTH-1:0].
//  Write addr3: edge_capture[i] cleared where writedata[i]=1; bits with writedata[i]=0 untouched.
//  Writes to addr0/addr1 ignored.
//  Simultaneous clear and new edge on same bit, same cycle: set wins (edge never lost).
//  irq combinational from registers; drops the cycle after the clearing write (or mask clear) takes effect.
//  Reset mid-operation: all state cleared immediately; pending captures lost; irq deasserts asynchronously.
// CONFIGURATION
//  PIO_IN_DEBOUNCE_EN defined: per-bit counter (clog2(DB_CYCLES+1) bits) after synchroniser.
//   Counter clears whenever sync_q[i]==f[i]; increments while they differ; on reaching DB_CYCLES-1,
//   f[i] <= sync_q[i] and counter clears. Glitches shorter than DB_CYCLES clks never reach f.
//   Latency becomes SYNC_STAGES+DB_CYCLES+1 clks. f resets to 0.
//  Not defined: f = sync_q directly; no counters synthesised; DB_CYCLES ignored.
// TESTING
//  1 Reset, WIDTH=8, EDGE_TYPE=0: read addr0/2/3 -> 0x0 each, irq=0.
//  2 in_port 0x00->0x05, mask=0x01: edge_capture=0x05 after SYNC_STAGES+1 clks, irq=1; write addr3 0x01
//    -> capture=0x04, irq=0; read addr0 -> 0x05.
//  3 EDGE_TYPE=1: pulse in_port[3] 0->1->0 -> capture=0x08 only once; EDGE_TYPE=2 same stimulus -> 0x08 on fall.
//  4 Write addr3 0x02 in same cycle bit1 edge detected -> capture bit1 stays 1.
//  5 PIO_IN_DEBOUNCE_EN, DB_CYCLES=16: 10-clk glitch on bit0 -> no capture; 20-clk level -> capture=0x01
//    exactly SYNC_STAGES+17 clks after change.
//  6 Assert reset_n low with capture=0xFF, mask=0xFF, irq=1 -> irq=0 and all registers 0 same cycle.

Source files
------------

// File: rtl/niosii_system_pio_in_edge.sv
// niosii_system_pio_in_edge
//   Avalon-MM input PIO (slave s1) for board switches and keys. Each input bit
//   is synchronised, optionally debounced, and edge-detected. Detected edges
//   are captured per bit until software clears them. Captured edges are ANDed
//   with an interrupt mask to form a level interrupt.
//
//   Optional feature macro: PIO_IN_DEBOUNCE_EN
//     defined   : a per-bit stability counter sits after the synchroniser.
//                 A change must hold for DB_CYCLES clocks before it becomes
//                 visible.
//     undefined : the synchroniser output is used directly, and no counters
//                 are built.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address: 0=data, 1=reserved, 2=irq_mask, 3=edge_capture
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data; only bits [WIDTH-1:0] are used
//   in_port     asynchronous external inputs
//   readdata    registered read data, 1-cycle latency, upper bits zero
//   irq         level interrupt = |(edge_capture & irq_mask)
//
// Bus handshake: there is no wait-state. A write is accepted on any rising
//   clk edge where chipselect=1 and write_n=0. readdata is reloaded on every
//   clock from the current address, whatever chipselect is. The value for an
//   address presented before edge N is therefore valid after edge N.
module niosii_system_pio_in_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int DB_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Synchroniser chain.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;

    always_comb begin
        sync_d[0] = in_port;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Filtered input value (filt) seen by the edge detector and data register.
    logic [WIDTH-1:0] filt;

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt_q [WIDTH];
    logic [CNT_W-1:0] db_cnt_d [WIDTH];
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;

    // The counter runs only while the synchronised input disagrees with the
    // filtered value. Any return to agreement restarts the window, so a short
    // glitch never reaches filt.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            db_cnt_d[i] = '0;
            if (sync_last[i] != filt_q[i]) begin
                if (db_cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
                    filt_d[i] = sync_last[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_last;
`endif

    // Edge detection against the filtered value delayed by one clock.
    logic [WIDTH-1:0] filt_prev_q;
    logic [WIDTH-1:0] edge_det;

    always_comb begin
        if (EDGE_TYPE == 1) begin
            edge_det = filt & ~filt_prev_q;
        end else if (EDGE_TYPE == 2) begin
            edge_det = ~filt & filt_prev_q;
        end else begin
            edge_det = filt ^ filt_prev_q;
        end
    end

    // Register file.
    logic             wr_en;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] edge_capture_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             unused_wdata;

    // Only writedata[WIDTH-1:0] is used. This net consumes the remaining bits.
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_en && address == 2'd2) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end

        cap_clr = '0;
        if (wr_en && address == 2'd3) begin
            cap_clr = writedata[WIDTH-1:0];
        end
        // The OR comes after the clear. A new edge in the same cycle as a clear
        // of the same bit therefore survives.
        edge_capture_d = (edge_capture_q & ~cap_clr) | edge_det;

        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = filt;
            2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_prev_q    <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            filt_prev_q    <= filt;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_niosii_system_pio_in_edge.sv
// Bench for niosii_system_pio_in_edge.
// The bench drives three instances (EDGE_TYPE 0, 1 and 2) from one shared bus.
// Read responses are checked by a monitor against an expected queue.
// The irq and reset behaviour are checked directly.
module tb_niosii_system_pio_in_edge;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DB = 16;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int LAT = SS + DB + 1;
`else
    localparam int LAT = SS + 1;
`endif

    logic         clk;
    logic         reset_n;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [W-1:0] in_port;
    logic [31:0]  rd0, rd1, rd2;
    logic         irq0, irq1, irq2;

    niosii_system_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(0), .DB_CYCLES(DB)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));
    niosii_system_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(1), .DB_CYCLES(DB)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));
    niosii_system_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(2), .DB_CYCLES(DB)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2));

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard.
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];
    string       name_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a read is accepted on the rising edge. Its response is compared
    // on the next falling edge.
    logic rd_pend;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_pend <= 1'b0;
        else          rd_pend <= chipselect & write_n;
    end

    always @(negedge clk) begin
        if (rd_pend) begin
            if (name_q.size() == 0) begin
                check("unexpected_read", 32'd1, 32'd0);
            end else begin
                string n;
                n = name_q.pop_front();
                check({n, "_any"},  rd0, exp_q0.pop_front());
                check({n, "_rise"}, rd1, exp_q1.pop_front());
                check({n, "_fall"}, rd2, exp_q2.pop_front());
            end
        end
    end

    // Driver tasks. Each starts and ends on a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input string name, input logic [1:0] a,
                            input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        name_q.push_back(name);
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
        exp_q2.push_back(e2);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic check_irq(input string name, input logic e0, input logic e1, input logic e2);
        check({name, "_any"},  {31'd0, irq0}, {31'd0, e0});
        check({name, "_rise"}, {31'd0, irq1}, {31'd0, e1});
        check({name, "_fall"}, {31'd0, irq2}, {31'd0, e2});
    endtask

    logic [W-1:0] old_v;
    logic [W-1:0] new_v;

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        tick(3);
        check_irq("irq_in_reset", 1'b0, 1'b0, 1'b0);
        check("rdata_in_reset", rd0, 32'd0);
        reset_n = 1'b1;

        // Reset state of the registers.
        bus_read("rst_data", 2'd0, 32'h0, 32'h0, 32'h0);
        bus_read("rst_mask", 2'd2, 32'h0, 32'h0, 32'h0);
        bus_read("rst_cap",  2'd3, 32'h0, 32'h0, 32'h0);
        check_irq("rst_irq", 1'b0, 1'b0, 1'b0);

        // Capture latency, mask, and write-1-to-clear.
        bus_write(2'd2, 32'h01);
        in_port = 8'h05;
        tick(LAT - 1);
        check_irq("lat_early_irq", 1'b0, 1'b0, 1'b0);
        tick(1);
        check_irq("lat_irq", 1'b1, 1'b1, 1'b0);
        bus_read("cap_05", 2'd3, 32'h05, 32'h05, 32'h00);
        bus_write(2'd3, 32'h01);
        check_irq("clr_irq", 1'b0, 1'b0, 1'b0);
        bus_read("cap_04", 2'd3, 32'h04, 32'h04, 32'h00);
        bus_read("data_05", 2'd0, 32'h05, 32'h05, 32'h05);
        bus_read("mask_01", 2'd2, 32'h01, 32'h01, 32'h01);
        bus_read("reserved", 2'd1, 32'h0, 32'h0, 32'h0);

        // Pulse on bit 3: rise, then fall.
        bus_write(2'd3, 32'hFF);
        in_port = 8'h0D;
        tick(LAT + 1);
        bus_read("pulse_rise", 2'd3, 32'h08, 32'h08, 32'h00);
        bus_write(2'd3, 32'h08);
        in_port = 8'h05;
        tick(LAT + 1);
        bus_read("pulse_fall", 2'd3, 32'h08, 32'h00, 32'h08);

        // Clear and a new edge on bit 1 in the same cycle: the set wins.
        bus_write(2'd3, 32'hFF);
        in_port = 8'h07;
        tick(LAT - 1);
        bus_write(2'd3, 32'h02);
        bus_read("set_wins", 2'd3, 32'h02, 32'h02, 32'h00);
        bus_write(2'd3, 32'h02);
        bus_read("cleared_after", 2'd3, 32'h00, 32'h00, 32'h00);

`ifdef PIO_IN_DEBOUNCE_EN
        // A 10-clock glitch is filtered; a held level is captured.
        bus_write(2'd2, 32'h10);
        in_port = 8'h17;
        tick(10);
        in_port = 8'h07;
        tick(LAT + 4);
        bus_read("glitch", 2'd3, 32'h00, 32'h00, 32'h00);
        in_port = 8'h17;
        tick(LAT - 1);
        check_irq("db_early_irq", 1'b0, 1'b0, 1'b0);
        tick(1);
        check_irq("db_irq", 1'b1, 1'b1, 1'b0);
        tick(4);
        bus_read("db_cap", 2'd3, 32'h10, 32'h10, 32'h00);
`endif

        // Reset in the middle of operation.
        bus_write(2'd3, 32'hFF);
        bus_write(2'd2, 32'hFF);
        old_v   = in_port;
        new_v   = ~old_v;
        in_port = new_v;
        tick(LAT + 1);
        bus_read("all_flip", 2'd3, 32'hFF, {24'd0, new_v}, {24'd0, old_v});
        check_irq("pre_reset_irq", 1'b1, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        check_irq("async_reset_irq", 1'b0, 1'b0, 1'b0);
        check("async_reset_rd_any",  rd0, 32'd0);
        check("async_reset_rd_rise", rd1, 32'd0);
        check("async_reset_rd_fall", rd2, 32'd0);
        tick(2);
        reset_n = 1'b1;
        bus_read("post_rst_mask", 2'd2, 32'h0, 32'h0, 32'h0);
        bus_read("post_rst_cap",  2'd3, 32'h0, 32'h0, 32'h0);
        // An input held high through reset release shows up as a rising edge.
        tick(LAT + 1);
        bus_read("release_edge", 2'd3, {24'd0, new_v}, {24'd0, new_v}, 32'h0);
        bus_read("release_data", 2'd0, {24'd0, new_v}, {24'd0, new_v}, {24'd0, new_v});
        check_irq("post_rst_irq", 1'b0, 1'b0, 1'b0);

        tick(2);
        check("queue_drained", name_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
